// File: rtl/phase_pkg.sv
// Shared definitions for the phase sequencer: state encoding, phase count and
// the bit positions of each phase in the phase_stb/phase_act vectors.
package phase_pkg;

  localparam int NUM_PH = 5;

  localparam int PH_FETCH   = 0;
  localparam int PH_DECODE  = 1;
  localparam int PH_EXECUTE = 2;
  localparam int PH_MEMORY  = 3;
  localparam int PH_WB      = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_DECODE  = 3'd2;
  localparam state_t ST_EXECUTE = 3'd3;
  localparam state_t ST_MEMORY  = 3'd4;
  localparam state_t ST_WB      = 3'd5;
  localparam state_t ST_HALTED  = 3'd6;

  // IDLE and HALTED map to an all-zero vector.
  function automatic logic [NUM_PH-1:0] phase_onehot(input state_t s);
    logic [NUM_PH-1:0] oh;
    oh = '0;
    case (s)
      ST_FETCH:   oh[PH_FETCH]   = 1'b1;
      ST_DECODE:  oh[PH_DECODE]  = 1'b1;
      ST_EXECUTE: oh[PH_EXECUTE] = 1'b1;
      ST_MEMORY:  oh[PH_MEMORY]  = 1'b1;
      ST_WB:      oh[PH_WB]      = 1'b1;
      default:    oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control inputs and phase/status outputs of the phase sequencer, bundled so
// the processor-side controller and the sequencer share one connection.
interface phase_sequencer_if #(
  parameter int CNT_W = 32
);
  import phase_pkg::*;

  logic              run;
  logic              stall;
  logic              halt_req;
  logic [NUM_PH-1:0] phase_stb;
  logic [NUM_PH-1:0] phase_act;
  logic              busy;
  logic              halted;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output run, stall, halt_req,
    input  phase_stb, phase_act, busy, halted, retire_cnt
  );

  modport slave (
    input  run, stall, halt_req,
    output phase_stb, phase_act, busy, halted, retire_cnt
  );

endinterface

// File: rtl/edge_tick.sv
// Converts rising edges of a clk-synchronous divided clock into 1-clk ticks.
// The arm flop suppresses a false edge when div_clk is already high at reset release.
module edge_tick (
  input  logic clk,
  input  logic reset_n,
  input  logic div_clk,
  output logic tick
);

  logic div_clk_q;
  logic armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_clk_q <= 1'b0;
      armed     <= 1'b0;
    end else begin
      div_clk_q <= div_clk;
      armed     <= 1'b1;
    end
  end

  assign tick = armed & div_clk & ~div_clk_q;

endmodule

// File: rtl/phase_sequencer.sv
// Steps a multi-cycle processor through FETCH..WRITEBACK on div_clk ticks,
// with stall, halt-at-instruction-boundary and a retired-instruction counter.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic div_clk,
  phase_sequencer_if.slave bus
);

  logic              tick;
  state_t            state;
  state_t            state_nxt;
  logic              halt_pend;
  logic              active;
  logic              adv;
  logic              retire;
  logic [NUM_PH-1:0] stb_q;
  logic [NUM_PH-1:0] act_q;
  logic              busy_q;
  logic              halted_q;
  logic [CNT_W-1:0]  cnt_q;

  edge_tick u_edge_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .div_clk (div_clk),
    .tick    (tick)
  );

  assign active = (state == ST_FETCH)   || (state == ST_DECODE) ||
                  (state == ST_EXECUTE) || (state == ST_MEMORY) ||
                  (state == ST_WB);
  assign adv    = tick & ~bus.stall;
  assign retire = (state == ST_WB) & adv;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (tick && bus.run) state_nxt = ST_FETCH;
      ST_FETCH:   if (adv) state_nxt = ST_DECODE;
      ST_DECODE:  if (adv) state_nxt = ST_EXECUTE;
      ST_EXECUTE: if (adv) state_nxt = ST_MEMORY;
      ST_MEMORY:  if (adv) state_nxt = ST_WB;
      ST_WB: begin
        // Halt takes priority over run=0 at the instruction boundary.
        if (adv) begin
          if (halt_pend)     state_nxt = ST_HALTED;
          else if (!bus.run) state_nxt = ST_IDLE;
          else               state_nxt = ST_FETCH;
        end
      end
      ST_HALTED:  if (!bus.run) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      halt_pend <= 1'b0;
      stb_q     <= '0;
      act_q     <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state    <= state_nxt;
      act_q    <= phase_onehot(state_nxt);
      stb_q    <= (state_nxt != state) ? phase_onehot(state_nxt) : '0;
      busy_q   <= (phase_onehot(state_nxt) != '0);
      halted_q <= (state_nxt == ST_HALTED);

      // Sticky until the boundary consumes it; a stalled WRITEBACK keeps it set.
      if (state_nxt == ST_HALTED || state_nxt == ST_IDLE)
        halt_pend <= 1'b0;
      else if (bus.halt_req && active)
        halt_pend <= 1'b1;

      if (retire)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.phase_stb  = stb_q;
  assign bus.phase_act  = act_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.retire_cnt = cnt_q;

endmodule
